// File: rtl/cpu_ctrl_fsm_param.sv
// Control sequencer for a shared-bus CPU: accepts {op, argX, argY} over valid/ready and
// drives one-hot register-load and bus-driver strobes, an ALU mode and status pulses.
module cpu_ctrl_fsm_param #(
  parameter int NUM_REGS = 8,
  parameter int OP_W     = 4,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int IW      = OP_W + 2 * ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IW-1:0]       instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [NUM_REGS-1:0] en_bus,
  output logic [NUM_REGS+1:0] tri_bus,
  output logic                a_en,
  output logic                g_en,
  output logic [1:0]          alu_op,
  output logic                done,
  output logic                illegal,
  output logic                halted,
  output logic [3:0]          o_dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready
  // are both high; instr_ready depends only on the current state, never on instr_valid.

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_MOVE = 4'd2,
    S_EX1  = 4'd3,
    S_EX2  = 4'd4,
    S_EX3  = 4'd5,
    S_NOP  = 4'd6,
    S_ILL  = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic                ready;
    logic [NUM_REGS-1:0] en;
    logic [NUM_REGS+1:0] drv;
    logic                a_en;
    logic                g_en;
    logic [1:0]          alu;
    logic                done;
    logic                illegal;
    logic                halted;
  } out_t;

  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MOVE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(7);

  function automatic state_t op_to_state(input logic [OP_W-1:0] op);
    state_t s;
    case (op)
      OP_LOAD:                        s = S_LOAD;
      OP_MOVE:                        s = S_MOVE;
      OP_ADD, OP_XOR, OP_SUB, OP_AND: s = S_EX1;
      OP_NOP:                         s = S_NOP;
      OP_HALT:                        s = S_HALT;
      default:                        s = S_ILL;
    endcase
    return s;
  endfunction

  // ALU op codes run ADD..AND consecutively, so the mode is the offset from ADD.
  function automatic out_t decode(input state_t s, input logic [IW-1:0] ir);
    out_t                o;
    logic [OP_W-1:0]     op;
    logic [ADDR_W-1:0]   ax;
    logic [ADDR_W-1:0]   ay;
    logic [OP_W-1:0]     alu_off;
    op      = ir[IW-1 -: OP_W];
    ax      = ir[2*ADDR_W-1 -: ADDR_W];
    ay      = ir[ADDR_W-1:0];
    alu_off = op - OP_ADD;
    o       = '0;
    case (s)
      S_IDLE: o.ready = 1'b1;
      S_LOAD: begin
        o.en           = NUM_REGS'(1) << ax;
        o.drv[NUM_REGS] = 1'b1;
        o.done         = 1'b1;
        o.ready        = 1'b1;
      end
      S_MOVE: begin
        o.en    = NUM_REGS'(1) << ax;
        o.drv   = (NUM_REGS+2)'(1) << ay;
        o.done  = 1'b1;
        o.ready = 1'b1;
      end
      S_EX1: begin
        o.drv  = (NUM_REGS+2)'(1) << ax;
        o.a_en = 1'b1;
      end
      S_EX2: begin
        o.drv  = (NUM_REGS+2)'(1) << ay;
        o.g_en = 1'b1;
        o.alu  = alu_off[1:0];
      end
      S_EX3: begin
        o.drv[NUM_REGS+1] = 1'b1;
        o.en              = NUM_REGS'(1) << ax;
        o.done            = 1'b1;
        o.ready           = 1'b1;
      end
      S_NOP: begin
        o.done  = 1'b1;
        o.ready = 1'b1;
      end
      S_ILL: begin
        o.illegal = 1'b1;
        o.done    = 1'b1;
        o.ready   = 1'b1;
      end
      S_HALT:  o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t          r_state;
  logic [IW-1:0]   r_ir;
  out_t            r_out;

  state_t          w_next_state;
  logic [IW-1:0]   w_next_ir;
  logic            w_accept;

  assign w_accept = instr_valid & r_out.ready;

  always_comb begin
    w_next_state = S_IDLE;
    w_next_ir    = r_ir;
    if (w_accept) begin
      w_next_ir    = instr;
      w_next_state = op_to_state(instr[IW-1 -: OP_W]);
    end else begin
      case (r_state)
        S_EX1:   w_next_state = S_EX2;
        S_EX2:   w_next_state = S_EX3;
        S_HALT:  w_next_state = S_HALT;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so they are a clean Moore decode of r_state/r_ir.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_out     <= '0;
      r_out.ready <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_ir    <= w_next_ir;
      r_out   <= decode(w_next_state, w_next_ir);
    end
  end

  assign instr_ready = r_out.ready;
  assign en_bus      = r_out.en;
  assign tri_bus     = r_out.drv;
  assign a_en        = r_out.a_en;
  assign g_en        = r_out.g_en;
  assign alu_op      = r_out.alu;
  assign done        = r_out.done;
  assign illegal     = r_out.illegal;
  assign halted      = r_out.halted;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm_param.sv
// Bench for cpu_ctrl_fsm_param: per-instruction cycle traces predicted from the opcode table,
// compared by a negedge monitor; a second instance covers NUM_REGS=16.
module tb_cpu_ctrl_fsm_param;

  localparam int N    = 8;
  localparam int IW   = 10;
  localparam int N16  = 16;
  localparam int IW16 = 12;
  localparam int VW   = N + (N + 2) + 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-register instance
  logic [IW-1:0]  instr = '0;
  logic           instr_valid = 1'b0;
  logic           instr_ready;
  logic [N-1:0]   en_bus;
  logic [N+1:0]   tri_bus;
  logic           a_en, g_en, done, illegal, halted;
  logic [1:0]     alu_op;
  logic [3:0]     dbg8;

  // 16-register instance
  logic [IW16-1:0] instr16 = '0;
  logic            valid16 = 1'b0;
  logic            ready16;
  logic [N16-1:0]  en16;
  logic [N16+1:0]  tri16;
  logic            a16, g16, done16, ill16, halt16;
  logic [1:0]      alu16;
  logic [3:0]      dbg16;

  cpu_ctrl_fsm_param #(.NUM_REGS(N), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .en_bus(en_bus), .tri_bus(tri_bus), .a_en(a_en), .g_en(g_en), .alu_op(alu_op),
    .done(done), .illegal(illegal), .halted(halted), .o_dbg_state(dbg8)
  );

  cpu_ctrl_fsm_param #(.NUM_REGS(N16), .OP_W(4)) dut16 (
    .clk(clk), .rst(rst), .instr(instr16), .instr_valid(valid16), .instr_ready(ready16),
    .en_bus(en16), .tri_bus(tri16), .a_en(a16), .g_en(g16), .alu_op(alu16),
    .done(done16), .illegal(ill16), .halted(halt16), .o_dbg_state(dbg16)
  );

  // scoreboard
  logic [VW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            in_halt  = 1'b0;
  logic [VW-1:0] obs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Trace vector: {en, tri, a_en, g_en, alu_op, done, illegal, halted, ready}; index -1 = none.
  function automatic logic [VW-1:0] mk(input int en_i, input int tri_i, input logic a,
                                       input logic g, input logic [1:0] alu, input logic dn,
                                       input logic il, input logic hl, input logic rdy);
    logic [N-1:0] e;
    logic [N+1:0] t;
    e = (en_i >= 0) ? (N'(1) << en_i) : '0;
    t = (tri_i >= 0) ? ((N + 2)'(1) << tri_i) : '0;
    return {e, t, a, g, alu, dn, il, hl, rdy};
  endfunction

  // Reference model: expected per-cycle trace for one accepted instruction.
  task automatic model_push(input logic [IW-1:0] ins);
    int op, x, y;
    logic [1:0] mode;
    op = int'(ins[9:6]);
    x  = int'(ins[5:3]);
    y  = int'(ins[2:0]);
    case (op)
      2: mode = 2'b00;
      3: mode = 2'b01;
      4: mode = 2'b10;
      default: mode = 2'b11;
    endcase
    if (op == 0)      exp_q.push_back(mk(x, N, 0, 0, 2'b00, 1, 0, 0, 1));
    else if (op == 1) exp_q.push_back(mk(x, y, 0, 0, 2'b00, 1, 0, 0, 1));
    else if (op >= 2 && op <= 5) begin
      exp_q.push_back(mk(-1, x, 1, 0, 2'b00, 0, 0, 0, 0));
      exp_q.push_back(mk(-1, y, 0, 1, mode, 0, 0, 0, 0));
      exp_q.push_back(mk(x, N + 1, 0, 0, 2'b00, 1, 0, 0, 1));
    end
    else if (op == 6) exp_q.push_back(mk(-1, -1, 0, 0, 2'b00, 1, 0, 0, 1));
    else if (op == 7) exp_q.push_back(mk(-1, -1, 0, 0, 2'b00, 0, 0, 1, 0));
    else              exp_q.push_back(mk(-1, -1, 0, 0, 2'b00, 1, 1, 0, 1));
  endtask

  // monitor: every non-idle cycle is compared against the next expected trace entry
  always @(negedge clk) begin
    if (rst) begin
      obs = {en_bus, tri_bus, a_en, g_en, alu_op, done, illegal, halted, instr_ready};
      if (obs[VW-1:1] != '0) begin
        if (exp_q.size() > 0) begin
          logic [VW-1:0] e;
          e = exp_q.pop_front();
          check("out_vec", 32'(obs), 32'(e));
          if (e[1]) in_halt = 1'b1;
        end else if (in_halt) begin
          check("halt_vec", 32'(obs), 32'(mk(-1, -1, 0, 0, 2'b00, 0, 0, 1, 0)));
        end else begin
          check("unexpected_out", 32'(obs), 32'd0);
        end
      end
    end
  end

  // driver
  task automatic issue(input logic [IW-1:0] ins);
    int waited;
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    waited      = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      check("ready_wait", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    model_push(ins);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    in_halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_rst", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] op;
    logic [2:0] x, y;

    // reset state
    #12;
    check("rst_outputs", 32'({en_bus, tri_bus, a_en, g_en, alu_op, done, illegal, halted}), 32'd0);
    check("rst_state", 32'(dbg8), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_rst", 32'(instr_ready), 32'd1);
    check("done_after_rst", 32'(done), 32'd0);

    // directed: LOAD R3, ADD R1,R2, MOVE/SUB back-to-back, illegal then NOP
    issue({4'h0, 3'd3, 3'd0});
    idle(2);
    issue({4'h2, 3'd1, 3'd2});
    idle(4);
    issue({4'h1, 3'd4, 3'd5});
    issue({4'h4, 3'd4, 3'd6});
    idle(4);
    issue({4'hC, 3'd2, 3'd7});
    issue({4'h6, 3'd0, 3'd0});
    idle(3);

    // reset while in EX2 drops every output at once
    issue({4'h2, 3'd1, 3'd2});
    @(posedge clk);
    #2;
    check("ex2_g_en", 32'(g_en), 32'd1);
    rst = 1'b0;
    #1;
    check("midop_rst_outputs", 32'({en_bus, tri_bus, a_en, g_en, alu_op, done, illegal, halted}), 32'd0);
    check("midop_rst_state", 32'(dbg8), 32'd0);
    exp_q.delete();
    in_halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_midop_rst", 32'(instr_ready), 32'd1);
    check("done_after_midop_rst", 32'(done), 32'd0);

    // randomized mix of every non-halting opcode, with and without gaps
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h7) op = 4'h6;
      x = 3'($urandom_range(0, 7));
      y = 3'($urandom_range(0, 7));
      issue({op, x, y});
      idle($urandom_range(0, 2));
    end
    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // HALT: a following valid LOAD must never execute
    issue({4'h7, 3'd0, 3'd0});
    @(negedge clk);
    instr       = {4'h0, 3'd3, 3'd0};
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_ready", 32'(instr_ready), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
    end
    instr_valid = 1'b0;
    reset_pulse();
    check("halt_cleared", 32'(halted), 32'd0);

    // 16-register instance: LOAD R3 then MOVE R15,R3
    @(negedge clk);
    instr16 = {4'h0, 4'd3, 4'd0};
    valid16 = 1'b1;
    @(posedge clk);
    #1;
    valid16 = 1'b0;
    @(negedge clk);
    check("r16_load_en", 32'(en16), 32'h0008);
    check("r16_load_tri", 32'(tri16), 32'h10000);
    check("r16_load_done", 32'(done16), 32'd1);
    @(negedge clk);
    check("r16_idle_en", 32'(en16), 32'd0);
    check("r16_idle_done", 32'(done16), 32'd0);
    instr16 = {4'h1, 4'd15, 4'd3};
    valid16 = 1'b1;
    @(posedge clk);
    #1;
    valid16 = 1'b0;
    @(negedge clk);
    check("r16_move_en", 32'(en16), 32'h8000);
    check("r16_move_tri", 32'(tri16), 32'h00008);
    check("r16_ready", 32'(ready16), 32'd1);

    idle(3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
